// File: rtl/ext_mem_bw_model.sv
// External-memory model with configurable read latency, optional single-port
// round-robin arbitration, out-of-range detection and saturating traffic counters.
module ext_mem_bw_model #(
  parameter int WIDTH        = 32,
  parameter int HEIGHT       = 1 << 20,
  parameter int READ_LATENCY = 1,
  parameter int SINGLE_PORT  = 0,
  parameter int CNT_WIDTH    = 48
) (
  input  logic                      clk,
  input  logic                      rst_in,
  input  logic [$clog2(HEIGHT)-1:0] read_addr,
  input  logic                      read_en,
  output logic                      read_ready,
  output logic [WIDTH-1:0]          qout,
  output logic                      qout_valid,
  input  logic [$clog2(HEIGHT)-1:0] write_addr,
  input  logic [WIDTH-1:0]          din,
  input  logic                      write_en,
  output logic                      write_ready,
  input  logic                      clear_counters,
  output logic [CNT_WIDTH-1:0]      rd_count,
  output logic [CNT_WIDTH-1:0]      wr_count,
  output logic [CNT_WIDTH-1:0]      conflict_count,
  output logic                      oob_error
);

  localparam int AW = $clog2(HEIGHT);
  localparam logic [AW:0] HEIGHT_L = (AW + 1)'(HEIGHT);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {ARB_READ = 1'b0, ARB_WRITE = 1'b1} arb_t;

  arb_t             arb_ptr;
  logic [WIDTH-1:0] mem [HEIGHT];
  logic             contested;
  logic             rd_acc;
  logic             wr_acc;
  logic             rd_oob;
  logic             wr_oob;
  logic [WIDTH-1:0] rd_word;

  logic [READ_LATENCY-1:0] rd_vld_p;
  logic [WIDTH-1:0]        rd_dat_p [READ_LATENCY];

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                   input logic inc);
    if (!inc || cnt == CNT_MAX) return cnt;
    return cnt + 1'b1;
  endfunction

  // Contention only exists when both sides share the single port.
  assign contested   = (SINGLE_PORT != 0) && read_en && write_en;
  assign read_ready  = !rst_in && (!contested || arb_ptr == ARB_READ);
  assign write_ready = !rst_in && (!contested || arb_ptr == ARB_WRITE);
  assign rd_acc      = read_en && read_ready;
  assign wr_acc      = write_en && write_ready;
  assign rd_oob      = {1'b0, read_addr} >= HEIGHT_L;
  assign wr_oob      = {1'b0, write_addr} >= HEIGHT_L;
  assign rd_word     = rd_oob ? '0 : mem[read_addr];

  always_ff @(posedge clk) begin
    if (wr_acc && !wr_oob) mem[write_addr] <= din;
  end

  // Stage p0 captures the word at acceptance (old data on a same-cycle write);
  // later stages shift it toward the output and hold when nothing arrives.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      rd_vld_p <= '0;
    end else begin
      for (int i = READ_LATENCY - 1; i > 0; i--) rd_vld_p[i] <= rd_vld_p[i-1];
      rd_vld_p[0] <= rd_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_acc) rd_dat_p[0] <= rd_word;
    for (int i = 1; i < READ_LATENCY; i++) begin
      if (rd_vld_p[i-1]) rd_dat_p[i] <= rd_dat_p[i-1];
    end
    if (rst_in) rd_dat_p[READ_LATENCY-1] <= '0;
  end

  assign qout       = rd_dat_p[READ_LATENCY-1];
  assign qout_valid = rd_vld_p[READ_LATENCY-1];

  always_ff @(posedge clk) begin
    if (rst_in) begin
      arb_ptr        <= ARB_READ;
      oob_error      <= 1'b0;
      rd_count       <= '0;
      wr_count       <= '0;
      conflict_count <= '0;
    end else begin
      if (contested) arb_ptr <= (arb_ptr == ARB_READ) ? ARB_WRITE : ARB_READ;
      if ((rd_acc && rd_oob) || (wr_acc && wr_oob)) oob_error <= 1'b1;
      if (clear_counters) begin
        rd_count       <= '0;
        wr_count       <= '0;
        conflict_count <= '0;
      end else begin
        rd_count       <= sat_inc(rd_count, rd_acc && !rd_oob);
        wr_count       <= sat_inc(wr_count, wr_acc && !wr_oob);
        conflict_count <= sat_inc(conflict_count, contested);
      end
    end
  end

endmodule

// File: tb/tb_ext_mem_bw_model.sv
// Bench for ext_mem_bw_model: three configurations (dual-port L=1, dual-port
// L=3 with 4-bit counters, single-port L=2) driven by directed and random traffic.
module tb_ext_mem_bw_model;
  localparam int W  = 32;
  localparam int H  = 1000;
  localparam int AW = 10;
  localparam int NI = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] ra   [NI];
  logic [AW-1:0] wa   [NI];
  logic [W-1:0]  din  [NI];
  logic          re   [NI];
  logic          we   [NI];
  logic          clr  [NI];
  logic          rr   [NI];
  logic          wrdy [NI];
  logic          qv   [NI];
  logic          oob  [NI];
  logic [W-1:0]  qout [NI];
  logic [47:0]   rd0, wc0, cf0;
  logic [3:0]    rd1, wc1, cf1;
  logic [7:0]    rd2, wc2, cf2;
  logic [63:0]   rdc  [NI];
  logic [63:0]   wrc  [NI];
  logic [63:0]   cfc  [NI];
  int checks = 0;
  int errors = 0;

  // Reference model state for the random test
  logic [W-1:0]    m_mem   [NI][H];
  bit              m_known [NI][H];
  bit              p_v     [NI][8];
  bit              p_dc    [NI][8];
  int              p_due   [NI][8];
  int              p_a     [NI][8];
  logic [W-1:0]    p_d     [NI][8];
  logic [W-1:0]    m_q     [NI];
  bit              m_qk    [NI];
  bit              m_oob   [NI];
  bit              m_ptrw  [NI];
  longint unsigned m_rd    [NI];
  longint unsigned m_wr    [NI];
  longint unsigned m_cf    [NI];

  assign rdc[0] = 64'(rd0);
  assign wrc[0] = 64'(wc0);
  assign cfc[0] = 64'(cf0);
  assign rdc[1] = 64'(rd1);
  assign wrc[1] = 64'(wc1);
  assign cfc[1] = 64'(cf1);
  assign rdc[2] = 64'(rd2);
  assign wrc[2] = 64'(wc2);
  assign cfc[2] = 64'(cf2);

  always #5 clk = ~clk;

  ext_mem_bw_model #(.WIDTH(W), .HEIGHT(H), .READ_LATENCY(1), .SINGLE_PORT(0), .CNT_WIDTH(48)) u0 (
    .clk(clk), .rst_in(rst), .read_addr(ra[0]), .read_en(re[0]), .read_ready(rr[0]),
    .qout(qout[0]), .qout_valid(qv[0]), .write_addr(wa[0]), .din(din[0]), .write_en(we[0]),
    .write_ready(wrdy[0]), .clear_counters(clr[0]), .rd_count(rd0), .wr_count(wc0),
    .conflict_count(cf0), .oob_error(oob[0]));

  ext_mem_bw_model #(.WIDTH(W), .HEIGHT(H), .READ_LATENCY(3), .SINGLE_PORT(0), .CNT_WIDTH(4)) u1 (
    .clk(clk), .rst_in(rst), .read_addr(ra[1]), .read_en(re[1]), .read_ready(rr[1]),
    .qout(qout[1]), .qout_valid(qv[1]), .write_addr(wa[1]), .din(din[1]), .write_en(we[1]),
    .write_ready(wrdy[1]), .clear_counters(clr[1]), .rd_count(rd1), .wr_count(wc1),
    .conflict_count(cf1), .oob_error(oob[1]));

  ext_mem_bw_model #(.WIDTH(W), .HEIGHT(H), .READ_LATENCY(2), .SINGLE_PORT(1), .CNT_WIDTH(8)) u2 (
    .clk(clk), .rst_in(rst), .read_addr(ra[2]), .read_en(re[2]), .read_ready(rr[2]),
    .qout(qout[2]), .qout_valid(qv[2]), .write_addr(wa[2]), .din(din[2]), .write_en(we[2]),
    .write_ready(wrdy[2]), .clear_counters(clr[2]), .rd_count(rd2), .wr_count(wc2),
    .conflict_count(cf2), .oob_error(oob[2]));

  function automatic int lat_of(input int i);
    return (i == 1) ? 3 : (i == 2) ? 2 : 1;
  endfunction

  function automatic int cw_of(input int i);
    return (i == 1) ? 4 : (i == 2) ? 8 : 48;
  endfunction

  function automatic bit sp_of(input int i);
    return (i == 2);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int i = 0; i < NI; i++) begin
      re[i] = 1'b0; we[i] = 1'b0; clr[i] = 1'b0;
      ra[i] = '0;   wa[i] = '0;   din[i] = '0;
    end
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin re[i] = 1'b1; we[i] = 1'b1; end
    tick();
    tick();
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (rr[i] !== 1'b0 || wrdy[i] !== 1'b0) begin
        errors++; $display("FAIL reset_ready u%0d: got %b/%b, expected 0/0", i, rr[i], wrdy[i]);
      end
      checks++;
      if (qv[i] !== 1'b0 || qout[i] !== '0) begin
        errors++; $display("FAIL reset_qout u%0d: got valid=%b qout=%h, expected 0/0", i, qv[i], qout[i]);
      end
      checks++;
      if (rdc[i] !== 64'd0 || wrc[i] !== 64'd0 || cfc[i] !== 64'd0 || oob[i] !== 1'b0) begin
        errors++; $display("FAIL reset_counters u%0d: got rd=%0d wr=%0d cf=%0d oob=%b, expected all 0",
                           i, rdc[i], wrc[i], cfc[i], oob[i]);
      end
    end
    rst = 1'b0;
    idle();
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rr[i] !== 1'b1 || wrdy[i] !== 1'b1) begin
        errors++; $display("FAIL dual_ready u%0d: got %b/%b, expected 1/1", i, rr[i], wrdy[i]);
      end
    end
    tick();
  endtask

  task automatic test_dual_basic();
    longint unsigned traffic;
    we[0] = 1'b1; wa[0] = 10'd5; din[0] = 32'hDEADBEEF;
    tick();
    we[0] = 1'b0; re[0] = 1'b1; ra[0] = 10'd5;
    tick();
    re[0] = 1'b0;
    checks++;
    if (qv[0] !== 1'b1 || qout[0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL basic_read: got valid=%b qout=%h, expected 1/deadbeef", qv[0], qout[0]);
    end
    checks++;
    if (rdc[0] !== 64'd1 || wrc[0] !== 64'd1) begin
      errors++; $display("FAIL basic_counts: got rd=%0d wr=%0d, expected 1/1", rdc[0], wrc[0]);
    end
    traffic = (rdc[0] + wrc[0]) * 64'(W);
    checks++;
    if (traffic != 64'd64) begin
      errors++; $display("FAIL basic_traffic: got %0d bits, expected 64", traffic);
    end
    tick();
    checks++;
    if (qv[0] !== 1'b0 || qout[0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL basic_hold: got valid=%b qout=%h, expected 0/deadbeef", qv[0], qout[0]);
    end
  endtask

  task automatic test_read_before_write();
    we[0] = 1'b1; wa[0] = 10'd7; din[0] = 32'h11;
    tick();
    re[0] = 1'b1; ra[0] = 10'd7; din[0] = 32'h22;
    tick();
    checks++;
    if (qv[0] !== 1'b1 || qout[0] !== 32'h11) begin
      errors++; $display("FAIL rbw_old: got valid=%b qout=%h, expected 1/11", qv[0], qout[0]);
    end
    we[0] = 1'b0;
    tick();
    re[0] = 1'b0;
    checks++;
    if (qv[0] !== 1'b1 || qout[0] !== 32'h22) begin
      errors++; $display("FAIL rbw_new: got valid=%b qout=%h, expected 1/22", qv[0], qout[0]);
    end
    checks++;
    if (rdc[0] !== 64'd3 || wrc[0] !== 64'd3) begin
      errors++; $display("FAIL rbw_counts: got rd=%0d wr=%0d, expected 3/3", rdc[0], wrc[0]);
    end
  endtask

  task automatic test_latency();
    for (int j = 0; j < 5; j++) begin
      we[1] = 1'b1; wa[1] = 10'(20 + j); din[1] = 32'(256 + j);
      tick();
    end
    we[1] = 1'b0;
    for (int n = 0; n < 9; n++) begin
      re[1] = (n < 5); ra[1] = 10'(20 + n);
      tick();
      checks++;
      if (qv[1] !== ((n >= 2) && (n <= 6))) begin
        errors++; $display("FAIL lat_valid n=%0d: got %b, expected %b", n, qv[1], (n >= 2) && (n <= 6));
      end
      if (n >= 2 && n <= 6) begin
        checks++;
        if (qout[1] !== 32'(256 + n - 2)) begin
          errors++; $display("FAIL lat_data n=%0d: got %h, expected %h", n, qout[1], 32'(256 + n - 2));
        end
      end
    end
    checks++;
    if (rdc[1] !== 64'd5 || wrc[1] !== 64'd5) begin
      errors++; $display("FAIL lat_counts: got rd=%0d wr=%0d, expected 5/5", rdc[1], wrc[1]);
    end
    // Reads in flight when reset hits must never emerge.
    for (int n = 0; n < 9; n++) begin
      rst = (n == 4); re[1] = (n <= 4); ra[1] = 10'(20 + n);
      tick();
      if (n == 2 || n == 3) begin
        checks++;
        if (qv[1] !== 1'b1 || qout[1] !== 32'(256 + n - 2)) begin
          errors++; $display("FAIL lat_pre_reset n=%0d: got %b/%h, expected 1/%h", n, qv[1], qout[1], 32'(256 + n - 2));
        end
      end
      if (n >= 4) begin
        checks++;
        if (qv[1] !== 1'b0 || rdc[1] !== 64'd0 || wrc[1] !== 64'd0) begin
          errors++; $display("FAIL lat_post_reset n=%0d: got valid=%b rd=%0d wr=%0d, expected 0/0/0", n, qv[1], rdc[1], wrc[1]);
        end
      end
      if (n == 4) begin
        checks++;
        if (qout[1] !== '0) begin
          errors++; $display("FAIL lat_reset_qout: got %h, expected 0", qout[1]);
        end
      end
    end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_single_port();
    re[2] = 1'b1; we[2] = 1'b1; ra[2] = 10'd4; wa[2] = 10'd4;
    for (int k = 0; k < 4; k++) begin
      din[2] = 32'(8'hA0 + k);
      #1;
      checks++;
      if (rr[2] !== (k % 2 == 0) || wrdy[2] !== (k % 2 == 1)) begin
        errors++; $display("FAIL sp_grant k=%0d: got r=%b w=%b, expected r=%b w=%b", k, rr[2], wrdy[2], k % 2 == 0, k % 2 == 1);
      end
      tick();
    end
    re[2] = 1'b0; we[2] = 1'b0;
    checks++;
    if (cfc[2] !== 64'd4 || rdc[2] !== 64'd2 || wrc[2] !== 64'd2) begin
      errors++; $display("FAIL sp_counts: got cf=%0d rd=%0d wr=%0d, expected 4/2/2", cfc[2], rdc[2], wrc[2]);
    end
    re[2] = 1'b1; we[2] = 1'b1; din[2] = 32'hB0;
    #1;
    checks++;
    if (rr[2] !== 1'b1 || wrdy[2] !== 1'b0) begin
      errors++; $display("FAIL sp_grant5: got r=%b w=%b, expected 1/0", rr[2], wrdy[2]);
    end
    tick();
    we[2] = 1'b0;
    tick();
    checks++;
    if (qv[2] !== 1'b1 || qout[2] !== 32'hA3) begin
      errors++; $display("FAIL sp_read5: got %b/%h, expected 1/a3", qv[2], qout[2]);
    end
    we[2] = 1'b1; din[2] = 32'hC0;
    #1;
    checks++;
    if (rr[2] !== 1'b0 || wrdy[2] !== 1'b1) begin
      errors++; $display("FAIL sp_ptr_kept: got r=%b w=%b, expected 0/1", rr[2], wrdy[2]);
    end
    tick();
    we[2] = 1'b0;
    tick();
    re[2] = 1'b0;
    checks++;
    if (qv[2] !== 1'b0 || qout[2] !== 32'hA3) begin
      errors++; $display("FAIL sp_gap: got %b/%h, expected 0/a3", qv[2], qout[2]);
    end
    tick();
    checks++;
    if (qv[2] !== 1'b1 || qout[2] !== 32'hC0) begin
      errors++; $display("FAIL sp_read8: got %b/%h, expected 1/c0", qv[2], qout[2]);
    end
    checks++;
    if (cfc[2] !== 64'd6 || rdc[2] !== 64'd5 || wrc[2] !== 64'd3) begin
      errors++; $display("FAIL sp_counts2: got cf=%0d rd=%0d wr=%0d, expected 6/5/3", cfc[2], rdc[2], wrc[2]);
    end
  endtask

  task automatic test_oob();
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    checks++;
    if (oob[0] !== 1'b0) begin
      errors++; $display("FAIL oob_initial: got %b, expected 0", oob[0]);
    end
    we[0] = 1'b1; wa[0] = 10'd488; din[0] = 32'h1234;
    tick();
    wa[0] = 10'd1000; din[0] = 32'hBAD;
    tick();
    we[0] = 1'b0;
    checks++;
    if (oob[0] !== 1'b1 || wrc[0] !== 64'd1) begin
      errors++; $display("FAIL oob_write: got oob=%b wr=%0d, expected 1/1", oob[0], wrc[0]);
    end
    re[0] = 1'b1; ra[0] = 10'd1023;
    tick();
    checks++;
    if (qv[0] !== 1'b1 || qout[0] !== '0 || rdc[0] !== 64'd0) begin
      errors++; $display("FAIL oob_read: got %b/%h rd=%0d, expected 1/0 rd=0", qv[0], qout[0], rdc[0]);
    end
    ra[0] = 10'd488;
    tick();
    re[0] = 1'b0;
    checks++;
    if (qv[0] !== 1'b1 || qout[0] !== 32'h1234 || rdc[0] !== 64'd1) begin
      errors++; $display("FAIL oob_mem_intact: got %b/%h rd=%0d, expected 1/1234 rd=1", qv[0], qout[0], rdc[0]);
    end
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    checks++;
    if (oob[0] !== 1'b1 || rdc[0] !== 64'd0 || wrc[0] !== 64'd0) begin
      errors++; $display("FAIL oob_sticky: got oob=%b rd=%0d wr=%0d, expected 1/0/0", oob[0], rdc[0], wrc[0]);
    end
  endtask

  task automatic test_saturation();
    clr[1] = 1'b1;
    tick();
    clr[1] = 1'b0;
    for (int n = 0; n < 20; n++) begin
      re[1] = 1'b1; ra[1] = 10'($urandom_range(0, 999));
      tick();
      checks++;
      if (rdc[1] !== 64'((n + 1 > 15) ? 15 : n + 1)) begin
        errors++; $display("FAIL sat_count n=%0d: got %0d, expected %0d", n, rdc[1], (n + 1 > 15) ? 15 : n + 1);
      end
    end
    clr[1] = 1'b1;
    tick();
    clr[1] = 1'b0;
    checks++;
    if (rdc[1] !== 64'd0) begin
      errors++; $display("FAIL sat_clear_wins: got %0d, expected 0", rdc[1]);
    end
    tick();
    re[1] = 1'b0;
    checks++;
    if (rdc[1] !== 64'd1 || cfc[1] !== 64'd0) begin
      errors++; $display("FAIL sat_after_clear: got rd=%0d cf=%0d, expected 1/0", rdc[1], cfc[1]);
    end
  endtask

  task automatic test_random();
    bit acc_r [NI];
    bit acc_w [NI];
    bit cont  [NI];
    bit e_rr, e_wr, e_v;
    int s, t;
    longint unsigned mx;
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    t = 0;
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 8; k++) p_v[i][k] = 1'b0;
      for (int a = 0; a < H; a++) m_known[i][a] = 1'b0;
      m_q[i] = '0; m_qk[i] = 1'b1; m_oob[i] = 1'b0; m_ptrw[i] = 1'b0;
      m_rd[i] = 0; m_wr[i] = 0; m_cf[i] = 0;
    end
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < NI; i++) begin
        re[i]  = ($urandom_range(0, 3) != 0);
        we[i]  = ($urandom_range(0, 1) != 0);
        clr[i] = ($urandom_range(0, 39) == 0);
        ra[i]  = ($urandom_range(0, 15) == 0) ? 10'(1000 + $urandom_range(0, 23)) : 10'($urandom_range(0, 15));
        wa[i]  = ($urandom_range(0, 15) == 0) ? 10'(1000 + $urandom_range(0, 23)) : 10'($urandom_range(0, 15));
        din[i] = $urandom();
      end
      #1;
      for (int i = 0; i < NI; i++) begin
        cont[i] = sp_of(i) && re[i] && we[i];
        e_rr = !rst && !(cont[i] && m_ptrw[i]);
        e_wr = !rst && !(cont[i] && !m_ptrw[i]);
        if (!sp_of(i) || re[i] || rst) begin
          checks++;
          if (rr[i] !== e_rr) begin
            errors++; $display("FAIL rnd_read_ready u%0d c=%0d: got %b, expected %b", i, c, rr[i], e_rr);
          end
        end
        if (!sp_of(i) || we[i] || rst) begin
          checks++;
          if (wrdy[i] !== e_wr) begin
            errors++; $display("FAIL rnd_write_ready u%0d c=%0d: got %b, expected %b", i, c, wrdy[i], e_wr);
          end
        end
        acc_r[i] = re[i] && e_rr;
        acc_w[i] = we[i] && e_wr;
      end
      tick();
      t++;
      for (int i = 0; i < NI; i++) begin
        mx = (64'd1 << cw_of(i)) - 64'd1;
        if (rst) begin
          for (int k = 0; k < 8; k++) p_v[i][k] = 1'b0;
          m_q[i] = '0; m_qk[i] = 1'b1; m_oob[i] = 1'b0; m_ptrw[i] = 1'b0;
          m_rd[i] = 0; m_wr[i] = 0; m_cf[i] = 0;
        end else begin
          // A write landing while an older read is still in flight leaves that
          // read's data open to either capture point, so it is not checked.
          if (acc_w[i] && wa[i] < H)
            for (int k = 0; k < 8; k++)
              if (p_v[i][k] && p_due[i][k] > t && p_a[i][k] == int'(wa[i])) p_dc[i][k] = 1'b1;
          if (acc_r[i]) begin
            s = (t + lat_of(i) - 1) % 8;
            p_v[i][s] = 1'b1; p_due[i][s] = t + lat_of(i) - 1; p_a[i][s] = int'(ra[i]);
            if (ra[i] >= H) begin
              p_d[i][s] = '0; p_dc[i][s] = 1'b0;
            end else begin
              p_d[i][s] = m_mem[i][ra[i]]; p_dc[i][s] = !m_known[i][ra[i]];
            end
          end
          if (acc_w[i] && wa[i] < H) begin
            m_mem[i][wa[i]] = din[i]; m_known[i][wa[i]] = 1'b1;
          end
          if ((acc_r[i] && ra[i] >= H) || (acc_w[i] && wa[i] >= H)) m_oob[i] = 1'b1;
          if (clr[i]) begin
            m_rd[i] = 0; m_wr[i] = 0; m_cf[i] = 0;
          end else begin
            if (acc_r[i] && ra[i] < H && m_rd[i] < mx) m_rd[i]++;
            if (acc_w[i] && wa[i] < H && m_wr[i] < mx) m_wr[i]++;
            if (cont[i] && m_cf[i] < mx) m_cf[i]++;
          end
          if (cont[i]) m_ptrw[i] = !m_ptrw[i];
        end
        s = t % 8;
        e_v = 1'b0;
        if (!rst && p_v[i][s] && p_due[i][s] == t) begin
          e_v = 1'b1;
          p_v[i][s] = 1'b0;
          if (p_dc[i][s]) m_qk[i] = 1'b0;
          else begin m_q[i] = p_d[i][s]; m_qk[i] = 1'b1; end
        end
        checks++;
        if (qv[i] !== e_v) begin
          errors++; $display("FAIL rnd_valid u%0d c=%0d: got %b, expected %b", i, c, qv[i], e_v);
        end
        if (m_qk[i]) begin
          checks++;
          if (qout[i] !== m_q[i]) begin
            errors++; $display("FAIL rnd_qout u%0d c=%0d: got %h, expected %h", i, c, qout[i], m_q[i]);
          end
        end
        checks++;
        if (rdc[i] !== m_rd[i] || wrc[i] !== m_wr[i] || cfc[i] !== m_cf[i]) begin
          errors++; $display("FAIL rnd_counters u%0d c=%0d: got %0d/%0d/%0d, expected %0d/%0d/%0d",
                             i, c, rdc[i], wrc[i], cfc[i], m_rd[i], m_wr[i], m_cf[i]);
        end
        checks++;
        if (oob[i] !== m_oob[i]) begin
          errors++; $display("FAIL rnd_oob u%0d c=%0d: got %b, expected %b", i, c, oob[i], m_oob[i]);
        end
      end
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_dual_basic();
    test_read_before_write();
    test_latency();
    test_single_port();
    test_oob();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ext_mem_bw_model.md
Name: ext_mem_bw_model

Overview:
Parametrised external-memory model with built-in bandwidth accounting. It is the successor to the fixed pseudo-2-port external memory instantiated beside top_chip in top_system.
- Adds configurable read latency, a single-port mode with round-robin arbitration, request handshakes, out-of-range detection and saturating read/write/conflict counters.
- Sits between top_chip's ext_mem_* interface and the testbench, which reads the counters to report off-chip traffic.

Parameters:
WIDTH, 32, data word width in bits
HEIGHT, 1<<20, number of words; need not be a power of two
READ_LATENCY, 1, cycles from accepted read to qout_valid; legal range 1..8
SINGLE_PORT, 0, 0 = independent read and write ports; 1 = one access per cycle, arbitrated
CNT_WIDTH, 48, width of each statistics counter

Ports:
clk  input  1  clock, all logic on rising edge
rst_in  input  1  reset (one clock; reset is synchronous and active-high)
read_addr  input  $clog2(HEIGHT)  read word address
read_en  input  1  read request
read_ready  output  1  read request accepted this cycle when read_en && read_ready
qout  output  WIDTH  read data
qout_valid  output  1  qout carries data of the read accepted READ_LATENCY cycles earlier
write_addr  input  $clog2(HEIGHT)  write word address
din  input  WIDTH  write data
write_en  input  1  write request
write_ready  output  1  write accepted this cycle when write_en && write_ready
clear_counters  input  1  synchronous clear of all counters
rd_count  output  CNT_WIDTH  accepted in-range reads
wr_count  output  CNT_WIDTH  accepted in-range writes
conflict_count  output  CNT_WIDTH  cycles with a contested access (SINGLE_PORT=1 only)
oob_error  output  1  sticky: an accepted access had address >= HEIGHT

Behaviour:
- Reset, while rst_in=1 at a clock edge:
  - qout=0, qout_valid=0, read pipeline valid bits cleared, so reads in flight are dropped with no qout_valid.
  - All counters = 0, oob_error = 0, round-robin pointer = READ.
  - Memory contents are not reset.
  - read_ready = write_ready = 0 during reset.
- SINGLE_PORT=0:
  - read_ready = write_ready = 1 whenever rst_in=0.
  - A same-cycle read and write to the same address returns the OLD data (read-before-write).
- SINGLE_PORT=1:
  - Only read_en set: read_ready=1. Only write_en set: write_ready=1. Both set: only the side selected by the pointer gets ready=1.
  - The pointer flips to the other side after each contested grant; uncontested cycles leave it unchanged.
  - conflict_count increments on each contested cycle.
  - Ready outputs are combinational from en, pointer and rst_in.
  - conflict_count stays 0 when SINGLE_PORT=0.
- Read path:
  - An accepted read enters a READ_LATENCY-deep pipeline (shift of valid+address or valid+data).
  - qout_valid is asserted exactly READ_LATENCY cycles after acceptance, for one cycle per read.
  - Back-to-back reads produce back-to-back qout_valid.
  - qout holds its last value when qout_valid=0.
- Write path: an accepted write updates the memory at that edge and is visible to a read accepted on a later cycle.
- Out of range (address >= HEIGHT):
  - Write: ignored, memory unchanged.
  - Read: qout=0 with qout_valid asserted normally.
  - In both cases the access is not counted and oob_error is set; oob_error clears only on reset.
- Counters:
  - Each increments by 1 per qualifying event and saturates at 2^CNT_WIDTH-1, with no wrap.
  - clear_counters=1 sets all three to 0 and beats a same-cycle increment. oob_error is unaffected by clear_counters.
- Traffic in bits = (rd_count + wr_count) * WIDTH; the bench computes this.

Test Plan:
- Dual-port, READ_LATENCY=1: write 0xDEADBEEF @5, then read @5 next cycle -> qout=0xDEADBEEF with qout_valid 1 cycle after accept; rd_count=1, wr_count=1.
- Same-cycle read/write @7 (old value 0x11, new 0x22) -> read returns 0x11; a later read returns 0x22.
- SINGLE_PORT=1, read_en and write_en both held 4 cycles -> grants R,W,R,W; conflict_count=4; rd_count=2; wr_count=2.
- READ_LATENCY=3: 5 back-to-back reads -> qout_valid high for cycles 3..7 after the first accept, data in order. Assert rst_in at cycle 4 -> no qout_valid after reset; counters read 0.
- HEIGHT=1000: write @1000 and read @1023 -> oob_error=1, memory unchanged, read qout=0 with qout_valid, wr_count and rd_count unchanged.
- CNT_WIDTH=4: 20 reads -> rd_count saturates at 15. clear_counters asserted on the same cycle as a read -> rd_count=0.
